exec_writeback: RTL

EXEC_WRITEBACK -- requirements
Module: exec_writeback

---
 rtl/exec_writeback_pkg.sv | 60 ++++++
 rtl/exec_writeback_status_flags.sv | 76 +++++++
 rtl/exec_writeback.sv | 99 +++++++++
 3 files changed

// File: rtl/exec_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_writeback_pkg
// Purpose  : Shared CPU constants: ALU mode encodings, writeback destination
//            encodings, explicit flag operations, status register bit indices
//            and the status register reset value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package exec_writeback_pkg;

    // ALU operating modes
    localparam logic [3:0] c_ALU_ADC = 4'd0;
    localparam logic [3:0] c_ALU_SBC = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_ORA = 4'd3;
    localparam logic [3:0] c_ALU_EOR = 4'd4;
    localparam logic [3:0] c_ALU_ASL = 4'd5;
    localparam logic [3:0] c_ALU_LSR = 4'd6;
    localparam logic [3:0] c_ALU_ROL = 4'd7;
    localparam logic [3:0] c_ALU_ROR = 4'd8;
    localparam logic [3:0] c_ALU_PASS = 4'd9;

    // Writeback destination select
    localparam logic [1:0] c_DST_NONE = 2'd0;
    localparam logic [1:0] c_DST_A    = 2'd1;
    localparam logic [1:0] c_DST_X    = 2'd2;
    localparam logic [1:0] c_DST_Y    = 2'd3;

    // Explicit flag operations
    localparam logic [2:0] c_FOP_NONE = 3'd0;
    localparam logic [2:0] c_FOP_SEC  = 3'd1;
    localparam logic [2:0] c_FOP_CLC  = 3'd2;
    localparam logic [2:0] c_FOP_SEI  = 3'd3;
    localparam logic [2:0] c_FOP_CLI  = 3'd4;
    localparam logic [2:0] c_FOP_SED  = 3'd5;
    localparam logic [2:0] c_FOP_CLD  = 3'd6;
    localparam logic [2:0] c_FOP_CLV  = 3'd7;

    // Status register bit positions {N,V,1,B,D,I,Z,C}
    localparam int c_P_C = 0;
    localparam int c_P_Z = 1;
    localparam int c_P_I = 2;
    localparam int c_P_D = 3;
    localparam int c_P_B = 4;
    localparam int c_P_U = 5;
    localparam int c_P_V = 6;
    localparam int c_P_N = 7;

    // flag_mask bit positions {N,V,Z,C}
    localparam int c_M_C = 0;
    localparam int c_M_Z = 1;
    localparam int c_M_V = 2;
    localparam int c_M_N = 3;

    // I set, unused bit 5 set
    localparam logic [7:0] c_P_RESET = 8'h24;

endpackage : exec_writeback_pkg
`default_nettype wire

// File: rtl/exec_writeback_status_flags.sv
`default_nettype none
// ============================================================================
// Module   : status_flags
// Purpose  : Combinational next-state for the status register P. Applies, in
//            increasing priority: masked transfer updates, explicit flag_op,
//            then a full p_load. Bit 5 always reads 1 and B always reads 0.
// Ports    : p_cur       - current P
//            xfer        - a writeback transfer happens this cycle
//            alu_out     - ALU result (source of Z, and N outside BIT mode)
//            carry_out   - ALU carry (source of C)
//            overflow    - ALU overflow (source of V outside BIT mode)
//            bit_src     - operand B bits [7:6] (N,V source in BIT mode)
//            flag_mask   - per-flag enable {N,V,Z,C}
//            bit_mode    - BIT semantics for N and V
//            flag_op     - explicit set/clear operation
//            p_load      - load P from p_load_data
//            p_load_data - value for p_load
//            p_next      - next P
// Revision : 1.0 - initial release
// ============================================================================
module status_flags
    import exec_writeback_pkg::*;
(
    input  logic [7:0] p_cur,
    input  logic       xfer,
    input  logic [7:0] alu_out,
    input  logic       carry_out,
    input  logic       overflow,
    input  logic [1:0] bit_src,
    input  logic [3:0] flag_mask,
    input  logic       bit_mode,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_load_data,
    output logic [7:0] p_next
);

    logic w_n_src;
    logic w_v_src;

    // BIT copies memory operand bits 7/6 into N/V; Z still reflects the AND
    assign w_n_src = bit_mode ? bit_src[1] : alu_out[7];
    assign w_v_src = bit_mode ? bit_src[0] : overflow;

    always_comb begin
        p_next = p_cur;

        if (xfer) begin
            if (flag_mask[c_M_C]) p_next[c_P_C] = carry_out;
            if (flag_mask[c_M_Z]) p_next[c_P_Z] = (alu_out == 8'h00);
            if (flag_mask[c_M_V]) p_next[c_P_V] = w_v_src;
            if (flag_mask[c_M_N]) p_next[c_P_N] = w_n_src;
        end

        // Explicit flag operations override a same-cycle transfer update
        case (flag_op)
            c_FOP_SEC: p_next[c_P_C] = 1'b1;
            c_FOP_CLC: p_next[c_P_C] = 1'b0;
            c_FOP_SEI: p_next[c_P_I] = 1'b1;
            c_FOP_CLI: p_next[c_P_I] = 1'b0;
            c_FOP_SED: p_next[c_P_D] = 1'b1;
            c_FOP_CLD: p_next[c_P_D] = 1'b0;
            c_FOP_CLV: p_next[c_P_V] = 1'b0;
            default:   ;
        endcase

        if (p_load) begin
            p_next = p_load_data;
        end

        p_next[c_P_U] = 1'b1;
        p_next[c_P_B] = 1'b0;
    end

endmodule : status_flags
`default_nettype wire

// File: rtl/exec_writeback.sv
`default_nettype none
// ============================================================================
// Module   : exec_writeback
// Purpose  : Execute-stage writeback. Commits ALU results into A/X/Y and
//            updates the status register P, with hold backpressure, explicit
//            flag operations and PLP-style P loads.
// Ports    : clk, reset (sync, active-high)
//            wb_valid / wb_ready - result handshake (ready = !hold && !reset)
//            hold                - freeze request
//            alu_out, carry_out, overflow, alu_b - ALU outputs / operand B
//            dst_sel             - 0 none, 1 A, 2 X, 3 Y
//            flag_mask           - per-flag update enable {N,V,Z,C}
//            bit_mode            - BIT flag sourcing
//            flag_op             - explicit flag set/clear
//            p_load, p_load_data - load P
//            reg_a, reg_x, reg_y, reg_p - architectural state
//            carry_flag          - current C, fed back to ALU carry_in
// Revision : 1.0 - initial release
// ============================================================================
module exec_writeback
    import exec_writeback_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_valid,
    output logic       wb_ready,
    input  logic       hold,
    input  logic [7:0] alu_out,
    input  logic       carry_out,
    input  logic       overflow,
    input  logic [7:0] alu_b,
    input  logic [1:0] dst_sel,
    input  logic [3:0] flag_mask,
    input  logic       bit_mode,
    input  logic [2:0] flag_op,
    input  logic       p_load,
    input  logic [7:0] p_load_data,
    output logic [7:0] reg_a,
    output logic [7:0] reg_x,
    output logic [7:0] reg_y,
    output logic [7:0] reg_p,
    output logic       carry_flag
);

    logic [7:0] r_a;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [7:0] r_p;
    logic [7:0] w_p_next;
    logic       w_xfer;
    logic [5:0] w_unused_alu_b;

    assign wb_ready       = !hold && !reset;
    assign w_xfer         = wb_valid && wb_ready;
    assign w_unused_alu_b = alu_b[5:0];

    status_flags u_status_flags (
        .p_cur       (r_p),
        .xfer        (w_xfer),
        .alu_out     (alu_out),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .bit_src     (alu_b[7:6]),
        .flag_mask   (flag_mask),
        .bit_mode    (bit_mode),
        .flag_op     (flag_op),
        .p_load      (p_load),
        .p_load_data (p_load_data),
        .p_next      (w_p_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= 8'h00;
            r_x <= 8'h00;
            r_y <= 8'h00;
            r_p <= c_P_RESET;
        end else begin
            if (w_xfer) begin
                case (dst_sel)
                    c_DST_A: r_a <= alu_out;
                    c_DST_X: r_x <= alu_out;
                    c_DST_Y: r_y <= alu_out;
                    default: ;
                endcase
            end
            // w_p_next equals r_p when no transfer, flag_op or p_load is active
            r_p <= w_p_next;
        end
    end

    assign reg_a      = r_a;
    assign reg_x      = r_x;
    assign reg_y      = r_y;
    assign reg_p      = r_p;
    assign carry_flag = r_p[c_P_C];

endmodule : exec_writeback
`default_nettype wire
